// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the command-to-AXI4-lite master.
// Holds the FSM state enum, the AXI response codes and the default prot value.
package axil_cmd_master_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    RD_REQ = 3'd3,
    RD_RSP = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-lite bus carrying the five channels between the master and a slave.
// The master modport drives requests and response readies; the slave modport is its mirror.
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axil_cmd_master.sv
// Turns single-beat register commands into AXI4-lite transactions, one in flight at a time,
// and returns exactly one response record per command.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// WR_REQ | AW and W offered; each drops after its own handshake
// WR_RSP | bready high, waiting for B
// RD_REQ | arvalid high, waiting for arready
// RD_RSP | rready high, waiting for R
// DONE   | rsp_valid high, holding the record until rsp_ready
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] AXI_PROT   = PROT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic [STRB_WIDTH-1:0] cmd_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [1:0]            rsp_resp_o,
  axil_cmd_master_if.master     m_axil
);

  localparam int                  LSB       = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << LSB) - ADDR_WIDTH'(1));

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  write_q;
  logic                  aw_done_q, w_done_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]            rsp_resp_q;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign aw_fire  = m_axil.awvalid && m_axil.awready;
  assign w_fire   = m_axil.wvalid && m_axil.wready;
  assign b_fire   = m_axil.bvalid && m_axil.bready;
  assign ar_fire  = m_axil.arvalid && m_axil.arready;
  assign r_fire   = m_axil.rvalid && m_axil.rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = cmd_write_i ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RSP;
      WR_RSP:  if (b_fire) state_d = DONE;
      RD_REQ:  if (ar_fire) state_d = RD_RSP;
      RD_RSP:  if (r_fire) state_d = DONE;
      DONE:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state only, so no ready ever waits on a valid.
  always_comb begin
    cmd_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    m_axil.awvalid = 1'b0;
    m_axil.wvalid  = 1'b0;
    m_axil.bready  = 1'b0;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    case (state_q)
      IDLE:    cmd_ready_o = rst_n;
      WR_REQ: begin
        m_axil.awvalid = !aw_done_q;
        m_axil.wvalid  = !w_done_q;
      end
      WR_RSP:  m_axil.bready  = 1'b1;
      RD_REQ:  m_axil.arvalid = 1'b1;
      RD_RSP:  m_axil.rready  = 1'b1;
      DONE:    rsp_valid_o    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q    <= cmd_addr_i & ADDR_MASK;
        data_q    <= cmd_data_i;
        strb_q    <= cmd_strb_i;
        write_q   <= cmd_write_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
      if (b_fire) begin
        rsp_data_q <= '0;
        rsp_resp_q <= m_axil.bresp;
      end
      if (r_fire) begin
        rsp_data_q <= m_axil.rdata;
        rsp_resp_q <= m_axil.rresp;
      end
    end
  end

  assign m_axil.awaddr = addr_q;
  assign m_axil.awprot = AXI_PROT;
  assign m_axil.wdata  = data_q;
  assign m_axil.wstrb  = strb_q;
  assign m_axil.araddr = addr_q;
  assign m_axil.arprot = AXI_PROT;

  assign rsp_write_o = write_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_resp_o  = rsp_resp_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a scripted AXI-lite slave with per-channel stall counts
// and a response consumer, with scenario tasks checking the hand-computed results.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;

  int checks = 0;
  int errors = 0;

  // results gathered by the slave driver for the last command
  int          r_lat, r_viol, r_aw_beats, r_w_beats, r_b_beats, r_ar_beats;
  int          r_aw_hold, r_w_hold, r_rsp_hold;
  logic        r_timeout, r_write;
  logic [31:0] r_addr, r_wdata, r_data;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_prot;
  logic [1:0]  r_resp;

  axil_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .cmd_strb_i  (cmd_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_write_o (rsp_write),
    .rsp_data_o  (rsp_data),
    .rsp_resp_o  (rsp_resp),
    .m_axil      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    rsp_ready = 1'b0;
  endtask

  // Issues one command and plays slave/consumer with the given stall counts.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         input int b_dly, input int ar_dly, input int r_dly, input int rsp_dly,
                         input logic [1:0] resp, input logic [31:0] rdat);
    int   n, aw_w, w_w, b_w, ar_w, r_w, rsp_w;
    logic aw_done, w_done, b_pend, b_started, r_pend, seen_rsp;
    logic aw_f, w_f, b_f, ar_f, r_f, rsp_f;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; rsp_w = 0;
    aw_done = 0; w_done = 0; b_pend = 0; b_started = 0; r_pend = 0; seen_rsp = 0;
    rsp_f = 0;
    r_lat = -1; r_viol = 0; r_aw_beats = 0; r_w_beats = 0; r_b_beats = 0; r_ar_beats = 0;
    r_aw_hold = 0; r_w_hold = 0; r_rsp_hold = 0; r_timeout = 0;
    r_addr = '0; r_wdata = '0; r_wstrb = '0; r_prot = 3'b111;
    r_write = 1'bx; r_data = 'x; r_resp = 'x;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      r_timeout = 1;
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_strb = strb;
    tick();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 32'hFFFF_FFFF; cmd_data = ~data;
    cmd_strb = ~strb;
    n = 1;
    while (n < 200) begin
      slave_idle();
      if (bus.awvalid) begin
        r_aw_hold++;
        if (r_aw_hold == 1) begin r_addr = bus.awaddr; r_prot = bus.awprot; end
        else if (bus.awaddr !== r_addr || bus.awprot !== r_prot) r_viol++;
        if (aw_done) r_viol++;
        if (aw_w >= aw_dly) bus.awready = 1'b1; else aw_w++;
      end
      if (bus.wvalid) begin
        r_w_hold++;
        if (r_w_hold == 1) begin r_wdata = bus.wdata; r_wstrb = bus.wstrb; end
        else if (bus.wdata !== r_wdata || bus.wstrb !== r_wstrb) r_viol++;
        if (w_done) r_viol++;
        if (w_w >= w_dly) bus.wready = 1'b1; else w_w++;
      end
      if (bus.arvalid) begin
        if (r_ar_beats == 0 && ar_w == 0) begin r_addr = bus.araddr; r_prot = bus.arprot; end
        else if (bus.araddr !== r_addr || bus.arprot !== r_prot) r_viol++;
        if (r_ar_beats != 0) r_viol++;
        if (ar_w >= ar_dly) bus.arready = 1'b1; else ar_w++;
      end
      if (b_pend) begin
        if (b_w >= b_dly) begin bus.bvalid = 1'b1; bus.bresp = resp; end else b_w++;
      end
      if (r_pend) begin
        if (r_w >= r_dly) begin bus.rvalid = 1'b1; bus.rresp = resp; bus.rdata = rdat; end
        else r_w++;
      end
      if (rsp_valid) begin
        r_rsp_hold++;
        if (!seen_rsp) begin
          seen_rsp = 1; r_lat = n; r_write = rsp_write; r_data = rsp_data; r_resp = rsp_resp;
        end else if (rsp_write !== r_write || rsp_data !== r_data || rsp_resp !== r_resp) begin
          r_viol++;
        end
        if (cmd_ready || bus.awvalid || bus.wvalid || bus.arvalid) r_viol++;
        if (rsp_w >= rsp_dly) rsp_ready = 1'b1; else rsp_w++;
      end
      aw_f  = bus.awvalid && bus.awready;
      w_f   = bus.wvalid && bus.wready;
      b_f   = bus.bvalid && bus.bready;
      ar_f  = bus.arvalid && bus.arready;
      r_f   = bus.rvalid && bus.rready;
      rsp_f = rsp_valid && rsp_ready;
      tick();
      n++;
      if (aw_f) begin aw_done = 1; r_aw_beats++; end
      if (w_f)  begin w_done = 1; r_w_beats++; end
      if (aw_done && w_done && !b_started) begin b_pend = 1; b_started = 1; end
      if (b_f)  begin b_pend = 0; r_b_beats++; end
      if (ar_f) begin r_pend = 1; r_ar_beats++; end
      if (r_f)  r_pend = 0;
      if (rsp_f) break;
    end
    slave_idle();
    if (!rsp_f) r_timeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got %b expected 0000000",
               {cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
    end
    checks++;
    if ({rsp_write, rsp_data, rsp_resp, bus.awaddr, bus.wdata} !== '0) begin
      errors++;
      $display("FAIL reset_regs: rsp_data=%h rsp_resp=%b awaddr=%h wdata=%h expected zeros",
               rsp_data, rsp_resp, bus.awaddr, bus.wdata);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    run_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    checks++;
    if (r_timeout !== 1'b0 || r_lat !== 3) begin
      errors++;
      $display("FAIL write_latency: got %0d (timeout %b) expected 3", r_lat, r_timeout);
    end
    checks++;
    if (r_addr !== 32'h10 || r_wdata !== 32'hDEAD_BEEF || r_wstrb !== 4'hF || r_prot !== 3'b000) begin
      errors++;
      $display("FAIL write_payload: addr=%h data=%h strb=%h prot=%b expected 10 deadbeef f 000",
               r_addr, r_wdata, r_wstrb, r_prot);
    end
    checks++;
    if (r_aw_beats !== 1 || r_w_beats !== 1 || r_b_beats !== 1) begin
      errors++;
      $display("FAIL write_beats: aw=%0d w=%0d b=%0d expected 1 1 1", r_aw_beats, r_w_beats, r_b_beats);
    end
    checks++;
    if (r_write !== 1'b1 || r_data !== 32'h0 || r_resp !== 2'b00) begin
      errors++;
      $display("FAIL write_rsp: write=%b data=%h resp=%b expected 1 0 00", r_write, r_data, r_resp);
    end
  endtask

  task automatic test_write_stall();
    run_cmd(1'b1, 32'h40, 32'hCAFE_0001, 4'h3, 3, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    checks++;
    if (r_aw_hold !== 4 || r_w_hold !== 1) begin
      errors++;
      $display("FAIL aw_stall_hold: aw=%0d w=%0d expected 4 1", r_aw_hold, r_w_hold);
    end
    checks++;
    if (r_b_beats !== 1 || r_viol !== 0 || r_lat !== 6) begin
      errors++;
      $display("FAIL aw_stall_b: b=%0d viol=%0d lat=%0d expected 1 0 6", r_b_beats, r_viol, r_lat);
    end
    run_cmd(1'b1, 32'h37, 32'h0BAD_F00D, 4'h8, 0, 2, 1, 0, 0, 0, 2'b10, 32'h0);
    checks++;
    if (r_addr !== 32'h34 || r_aw_hold !== 1 || r_w_hold !== 3) begin
      errors++;
      $display("FAIL w_stall_addr: addr=%h aw=%0d w=%0d expected 34 1 3", r_addr, r_aw_hold, r_w_hold);
    end
    checks++;
    if (r_lat !== 6 || r_resp !== 2'b10 || r_data !== 32'h0 || r_viol !== 0) begin
      errors++;
      $display("FAIL w_stall_rsp: lat=%0d resp=%b data=%h viol=%0d expected 6 10 0 0",
               r_lat, r_resp, r_data, r_viol);
    end
  endtask

  task automatic test_read();
    run_cmd(1'b0, 32'h23, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b10, 32'h1234_5678);
    checks++;
    if (r_addr !== 32'h20 || r_ar_beats !== 1 || r_aw_beats !== 0) begin
      errors++;
      $display("FAIL read_addr: araddr=%h ar=%0d aw=%0d expected 20 1 0", r_addr, r_ar_beats, r_aw_beats);
    end
    checks++;
    if (r_write !== 1'b0 || r_data !== 32'h1234_5678 || r_resp !== 2'b10 || r_lat !== 3) begin
      errors++;
      $display("FAIL read_rsp: write=%b data=%h resp=%b lat=%0d expected 0 12345678 10 3",
               r_write, r_data, r_resp, r_lat);
    end
    run_cmd(1'b0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 2, 1, 0, 2'b11, 32'hA5A5_0F0F);
    checks++;
    if (r_lat !== 6 || r_data !== 32'hA5A5_0F0F || r_resp !== 2'b11 || r_viol !== 0) begin
      errors++;
      $display("FAIL read_stall: lat=%0d data=%h resp=%b viol=%0d expected 6 a5a50f0f 11 0",
               r_lat, r_data, r_resp, r_viol);
    end
  endtask

  task automatic test_rsp_stall();
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 2'b01, 32'h5555_AAAA);
    checks++;
    if (r_rsp_hold !== 6 || r_viol !== 0) begin
      errors++;
      $display("FAIL rsp_stall_hold: cycles=%0d viol=%0d expected 6 0", r_rsp_hold, r_viol);
    end
    checks++;
    if (r_data !== 32'h5555_AAAA || r_resp !== 2'b01) begin
      errors++;
      $display("FAIL rsp_stall_data: data=%h resp=%b expected 5555aaaa 01", r_data, r_resp);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_stall_idle: cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_unexpected();
    bus.bvalid = 1'b1; bus.bresp = 2'b11; bus.rvalid = 1'b1; bus.rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.bready !== 1'b0 || bus.rready !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_resp: bready=%b rready=%b cmd_ready=%b rsp_valid=%b expected 0 0 1 0",
                 bus.bready, bus.rready, cmd_ready, rsp_valid);
      end
    end
    slave_idle();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_data = 32'h1111_2222; cmd_strb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0;
    checks++;
    if (bus.bready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: bready=%b expected 1", bus.bready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_drop: got %b expected 0000000",
               {cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
    end
    tick();
    rst_n = 1'b1;
    bus.bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || bus.bready !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle: cmd_ready=%b rsp_valid=%b bready=%b expected 1 0 0",
                 cmd_ready, rsp_valid, bus.bready);
      end
    end
    slave_idle();
  endtask

  task automatic test_back_to_back();
    logic        wr;
    logic [31:0] addr, data, rdat;
    logic [3:0]  strb;
    logic [1:0]  resp;
    for (int i = 0; i < 50; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom; data = $urandom; rdat = $urandom;
      strb = 4'($urandom_range(0, 15));
      resp = 2'($urandom_range(0, 3));
      run_cmd(wr, addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), resp, rdat);
      checks++;
      if (r_timeout !== 1'b0 || r_viol !== 0 || r_addr !== (addr & 32'hFFFF_FFFC)) begin
        errors++;
        $display("FAIL b2b_req[%0d]: timeout=%b viol=%0d addr=%h expected 0 0 %h",
                 i, r_timeout, r_viol, r_addr, addr & 32'hFFFF_FFFC);
      end
      checks++;
      if (r_write !== wr || r_resp !== resp || r_data !== (wr ? 32'h0 : rdat)) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: write=%b resp=%b data=%h expected %b %b %h",
                 i, r_write, r_resp, r_data, wr, resp, wr ? 32'h0 : rdat);
      end
      checks++;
      if (wr ? (r_aw_beats !== 1 || r_w_beats !== 1 || r_b_beats !== 1 || r_ar_beats !== 0 ||
                r_wdata !== data || r_wstrb !== strb)
             : (r_ar_beats !== 1 || r_aw_beats !== 0 || r_w_beats !== 0)) begin
        errors++;
        $display("FAIL b2b_beats[%0d]: aw=%0d w=%0d b=%0d ar=%0d wdata=%h wstrb=%h expected wr=%b data=%h strb=%h",
                 i, r_aw_beats, r_w_beats, r_b_beats, r_ar_beats, r_wdata, r_wstrb, wr, data, strb);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read();
    test_rsp_stall();
    test_unexpected();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
